temp_sampler: RTL and testbench

Measurement controller directly downstream of the temperature oscillator counter. It gates the oscillator on for a fixed window of `clk` cycles and holds the counter in reset between windows. After each window it captures the frozen count and averages 2^AVG_LOG2 windows. It presents the result on a valid/ready interface to the register or readout logic. Counter and oscillator stay under this block's control; nothing else drives their reset or enable.

---
 rtl/temp_pkg.sv | 33 +++
 rtl/temp_phase_timer.sv | 43 ++++
 rtl/temp_sampler.sv | 170 +++++++++++++++++
 tb/tb_temp_sampler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_pkg.sv
// ---------------------------------------------------------------------------
// temp_pkg
// Shared definitions for the temperature-oscillator measurement controller:
// the controller state encoding, the fixed counter-clear phase length and the
// helpers used to size the phase timer.
// ---------------------------------------------------------------------------
package temp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_GATE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_OUTPUT
  } temp_sampler_state_t;

  // Cycles the counter is held in reset before each gate window.
  localparam int TEMP_CLEAR_CYCLES = 2;

  function automatic int temp_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // The timer is loaded with (phase length - 1) and counts down to zero, so
  // it only has to represent values up to max_cycles - 1.
  function automatic int temp_timer_width(input int max_cycles);
    return (max_cycles < 2) ? 1 : $clog2(max_cycles);
  endfunction

endpackage

// File: rtl/temp_phase_timer.sv
// ---------------------------------------------------------------------------
// temp_phase_timer
// Loadable down-counter shared by the CLEAR, GATE and SETTLE phases.
// Loading value L-1 makes 'done' rise after L cycles in the phase: 'done' is
// high while the remaining count is zero.
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous, active-high
//   load       : load strobe (takes priority over counting)
//   load_value : phase length minus one
//   done       : current phase ends at the next edge
// ---------------------------------------------------------------------------
module temp_phase_timer
  import temp_pkg::*;
#(
  parameter  int MAX_CYCLES = 256,
  localparam int CW         = temp_timer_width(MAX_CYCLES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  output logic          done
);

  logic [CW-1:0] remaining;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= load_value;
    end else if (remaining != '0) begin
      remaining <= remaining - CW'(1);
    end
  end

  assign done = (remaining == '0);

endmodule

// File: rtl/temp_sampler.sv
// ---------------------------------------------------------------------------
// temp_sampler
// Gates the temperature oscillator on for a fixed window, holds its counter in
// reset between windows, captures the frozen count after a settle delay and
// averages 2^AVG_LOG2 windows. Results are offered on a valid/ready port.
//
// Ports
//   clk, reset  : clock and synchronous active-high reset
//   start       : begin a batch (only honoured in IDLE)
//   continuous  : at the output handshake, start the next batch at once
//   count       : oscillator counter value (frozen while osc_en = 0)
//   osc_en      : oscillator enable (registered)
//   cnt_reset   : counter reset, active-high (registered)
//   busy        : controller not idle
//   valid/ready : result handshake
//   data        : floor(sum of windows / 2^AVG_LOG2)
//   ovf         : some window in the batch read all-ones
// ---------------------------------------------------------------------------
module temp_sampler
  import temp_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int GATE_CYCLES   = 256,
  parameter int SETTLE_CYCLES = 4,
  parameter int AVG_LOG2      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic [WIDTH-1:0] count,
  output logic             osc_en,
  output logic             cnt_reset,
  output logic             busy,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             ovf
);

  localparam int NUM_WINDOWS = 1 << AVG_LOG2;
  localparam int SUM_W       = WIDTH + AVG_LOG2;
  localparam int IDX_W       = AVG_LOG2 + 1;
  localparam int TIMER_MAX   = temp_max3(GATE_CYCLES, SETTLE_CYCLES, TEMP_CLEAR_CYCLES);
  localparam int TW          = temp_timer_width(TIMER_MAX);

  temp_sampler_state_t state, next_state;

  logic             timer_load;
  logic [TW-1:0]    timer_value;
  logic             timer_done;

  logic [SUM_W-1:0] sum;
  logic [IDX_W-1:0] idx;
  logic             flag;

  logic [SUM_W-1:0] sum_next;
  logic [IDX_W-1:0] idx_next;
  logic             flag_next;
  logic             last_window;
  logic             handshake;
  logic             batch_clear;

  temp_phase_timer #(
    .MAX_CYCLES (TIMER_MAX)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  // valid is exactly "state == OUTPUT", so this is the consumer handshake.
  assign handshake   = valid && ready;
  assign sum_next    = sum + SUM_W'(count);
  assign flag_next   = flag | (count == '1);
  assign idx_next    = idx + IDX_W'(1);
  assign last_window = (idx_next == IDX_W'(NUM_WINDOWS));
  assign batch_clear = ((state == ST_IDLE) && start) || (handshake && continuous);

  // -------------------------------------------------------------------------
  // Next-state logic and timer loading
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path through
    // the case statements can infer a latch.
    next_state  = state;
    timer_load  = 1'b0;
    timer_value = '0;

    unique case (state)
      ST_IDLE:    if (start)      next_state = ST_CLEAR;
      ST_CLEAR:   if (timer_done) next_state = ST_GATE;
      ST_GATE:    if (timer_done) next_state = ST_SETTLE;
      ST_SETTLE:  if (timer_done) next_state = ST_CAPTURE;
      ST_CAPTURE: next_state = last_window ? ST_OUTPUT : ST_CLEAR;
      ST_OUTPUT:  if (handshake)  next_state = continuous ? ST_CLEAR : ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase

    // The timer is loaded on the edge that enters a timed phase.
    if (next_state != state) begin
      unique case (next_state)
        ST_CLEAR: begin
          timer_load  = 1'b1;
          timer_value = TW'(TEMP_CLEAR_CYCLES - 1);
        end
        ST_GATE: begin
          timer_load  = 1'b1;
          timer_value = TW'(GATE_CYCLES - 1);
        end
        ST_SETTLE: begin
          timer_load  = 1'b1;
          timer_value = TW'(SETTLE_CYCLES - 1);
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State register and registered Moore outputs (decoded from next_state so
  // they change on the same edge as the state itself).
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      osc_en    <= 1'b0;
      cnt_reset <= 1'b1;
      busy      <= 1'b0;
      valid     <= 1'b0;
    end else begin
      state     <= next_state;
      osc_en    <= (next_state == ST_GATE);
      cnt_reset <= (next_state == ST_IDLE) || (next_state == ST_CLEAR) ||
                   (next_state == ST_OUTPUT);
      busy      <= (next_state != ST_IDLE);
      valid     <= (next_state == ST_OUTPUT);
    end
  end

  // -------------------------------------------------------------------------
  // Accumulator, window index, overflow flag and result registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sum  <= '0;
      idx  <= '0;
      flag <= 1'b0;
      data <= '0;
      ovf  <= 1'b0;
    end else if (batch_clear) begin
      sum  <= '0;
      idx  <= '0;
      flag <= 1'b0;
    end else if (state == ST_CAPTURE) begin
      sum  <= sum_next;
      idx  <= idx_next;
      flag <= flag_next;
      // Result registers change only on the edge that enters OUTPUT, so they
      // hold through backpressure and after the handshake.
      if (last_window) begin
        data <= sum_next[SUM_W-1:AVG_LOG2];
        ovf  <= flag_next;
      end
    end
  end

endmodule

// File: tb/tb_temp_sampler.sv
// ---------------------------------------------------------------------------
// tb_temp_sampler
// Directed bench for temp_sampler with default parameters. A behavioural
// oscillator counter counts up to a per-window target while osc_en is high;
// expected results are queued when a batch is launched and compared when the
// DUT presents valid. Inputs are driven and outputs sampled on the falling
// edge.
// ---------------------------------------------------------------------------
module tb_temp_sampler;

  localparam int WIDTH   = 8;
  localparam int LATENCY = 1053;  // cycle index of first valid, start edge = t

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             continuous = 1'b0;
  logic             ready = 1'b1;
  logic [WIDTH-1:0] count;
  logic             osc_en, cnt_reset, busy, valid, ovf;
  logic [WIDTH-1:0] data;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             ovf;
  } result_t;

  result_t exp_q[$];
  int      tgt_q[$];
  int      burst_q[$];

  int checks = 0;
  int failures = 0;
  int overlap_cnt = 0;

  temp_sampler dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .continuous (continuous),
    .count      (count),
    .osc_en     (osc_en),
    .cnt_reset  (cnt_reset),
    .busy       (busy),
    .valid      (valid),
    .ready      (ready),
    .data       (data),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  // Behavioural oscillator counter: cleared by cnt_reset, counts while
  // osc_en is high until it reaches the target taken at the start of a burst.
  logic [WIDTH-1:0] cnt_model = '0;
  logic             osc_d = 1'b0;
  int               cur_tgt = 0;
  int               run_len = 0;

  assign count = cnt_model;

  always @(posedge clk) begin
    if (osc_en && !osc_d) begin
      if (tgt_q.size() != 0) cur_tgt = tgt_q.pop_front();
      else                   cur_tgt = 0;
    end
    osc_d <= osc_en;
    if (cnt_reset)                         cnt_model <= '0;
    else if (osc_en && cnt_model < cur_tgt) cnt_model <= cnt_model + 1'b1;
  end

  // Burst-length and enable/reset overlap monitor.
  always @(posedge clk) begin
    if (osc_en && cnt_reset) overlap_cnt <= overlap_cnt + 1;
    if (osc_en) begin
      run_len <= run_len + 1;
    end else if (run_len != 0) begin
      burst_q.push_back(run_len);
      run_len <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_batch(input int a, input int b, input int c, input int d);
    result_t r;
    int      sum;
    tgt_q.push_back(a);
    tgt_q.push_back(b);
    tgt_q.push_back(c);
    tgt_q.push_back(d);
    sum    = a + b + c + d;
    r.data = WIDTH'(sum >> 2);
    r.ovf  = (a == 255) || (b == 255) || (c == 255) || (d == 255);
    exp_q.push_back(r);
  endtask

  // Pulse start for one edge; on return one edge has elapsed (cycle t+1).
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Advance until valid is seen, counting edges from the start edge.
  task automatic wait_valid(input string tag, input int c0, output int cycles);
    cycles = c0;
    while (!valid && cycles < 3000) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_valid_seen"}, valid, 1'b1);
  endtask

  task automatic pop_compare(input string tag);
    result_t e;
    check({tag, "_sb_nonempty"}, exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_data"}, data, e.data);
      check({tag, "_ovf"}, ovf, e.ovf);
    end
  endtask

  task automatic check_bursts(input string tag);
    check({tag, "_burst_count"}, burst_q.size(), 4);
    foreach (burst_q[i]) check({tag, "_burst_len"}, burst_q[i], 256);
    burst_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_osc_en"}, osc_en, 1'b0);
    check({tag, "_cnt_reset"}, cnt_reset, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_valid"}, valid, 1'b0);
    check({tag, "_data"}, data, 0);
    check({tag, "_ovf"}, ovf, 1'b0);
  endtask

  initial begin
    int cyc;
    int c;
    logic [WIDTH-1:0] held;
    logic bp_ok;

    // Reset, then idle.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_idle_outputs("idle");

    // Batch 1: four windows of 100, ready high.
    push_batch(100, 100, 100, 100);
    pulse_start();
    check("b1_clear_busy", busy, 1'b1);
    check("b1_clear_cnt_reset", cnt_reset, 1'b1);
    check("b1_clear_osc_en", osc_en, 1'b0);
    wait_valid("b1", 1, cyc);
    check("b1_latency", cyc, LATENCY);
    pop_compare("b1");
    check_bursts("b1");
    @(negedge clk);
    check("b1_valid_drop", valid, 1'b0);
    check("b1_back_idle", busy, 1'b0);

    // Batch 2: truncating average.
    push_batch(10, 11, 11, 11);
    pulse_start();
    wait_valid("b2", 1, cyc);
    pop_compare("b2");
    check_bursts("b2");
    @(negedge clk);

    // Batch 3: one saturated window.
    push_batch(255, 200, 200, 200);
    pulse_start();
    wait_valid("b3", 1, cyc);
    pop_compare("b3");
    check_bursts("b3");
    @(negedge clk);

    // Batch 4: backpressure, then continuous hand-over.
    ready = 1'b0;
    push_batch(50, 60, 70, 80);
    pulse_start();
    wait_valid("b4", 1, cyc);
    pop_compare("b4");
    held  = data;
    bp_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (data !== held || osc_en !== 1'b0 || valid !== 1'b1 || cnt_reset !== 1'b1)
        bp_ok = 1'b0;
    end
    check("bp_hold", bp_ok, 1'b1);
    check_bursts("b4");
    check("bp_no_new_window", burst_q.size(), 0);

    push_batch(30, 30, 30, 30);
    continuous = 1'b1;
    ready      = 1'b1;
    @(negedge clk);  // handshake edge has passed: CLEAR expected
    continuous = 1'b0;
    check("cont_clear_valid", valid, 1'b0);
    check("cont_clear_busy", busy, 1'b1);
    check("cont_clear_cnt_reset", cnt_reset, 1'b1);
    check("cont_clear_data_held", data, held);
    wait_valid("b5", 1, cyc);
    check("b5_latency", cyc, LATENCY);
    pop_compare("b5");
    check_bursts("b5");
    @(negedge clk);
    check("b5_back_idle", busy, 1'b0);
    check("b5_data_persists", data, 30);

    // Reset in the middle of a gate window.
    push_batch(100, 100, 100, 100);
    pulse_start();
    c = 0;
    while (!osc_en && c < 20) begin
      @(negedge clk);
      c++;
    end
    repeat (50) @(negedge clk);
    check("rst_mid_gate_active", osc_en, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_mid_gate");
    @(negedge clk);
    reset = 1'b0;
    tgt_q.delete();
    exp_q.delete();
    burst_q.delete();
    repeat (3) @(negedge clk);

    // start pulsed during SETTLE must not disturb the batch.
    push_batch(20, 40, 60, 80);
    pulse_start();
    c = 1;
    while (!osc_en && c < 100) begin
      @(negedge clk);
      c++;
    end
    while (osc_en && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check("settle_osc_en", osc_en, 1'b0);
    check("settle_cnt_reset", cnt_reset, 1'b0);
    check("settle_busy", busy, 1'b1);
    start = 1'b1;
    @(negedge clk);
    c++;
    start = 1'b0;
    wait_valid("b6", c, cyc);
    check("b6_latency", cyc, LATENCY);
    pop_compare("b6");
    check_bursts("b6");
    @(negedge clk);

    check("no_enable_reset_overlap", overlap_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
